edge_burst_det: RTL and testbench
=================================

# edge_burst_det

Multi-channel, parametrised edge-burst detector: per channel, counts qualifying edges on `sig_in` inside a sliding window of `WIN` cycles and pulses a flag when the count reaches a runtime threshold. It generalises the single-channel 3-in-5 rising-edge checker with configurable channel count, window depth, threshold, edge polarity, enable/clear control, sticky status and a hit counter. It sits in the input-monitoring path, with flags feeding interrupt/status logic.

## Interface
- `N_CH`, default 4: number of independent channels (1..16).
- `WIN`, default 8: window length in cycles (2..32).
- `TH_W`, default 4: threshold field width; `CNT_W = $clog2(WIN+1)` is derived internally.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sig_in` input N_CH: monitored signals, synchronous to `clk`.
- `enable` input 1: 1 = detect; 0 = new edge events are forced to 0.
- `edge_mode` input 2: 00 rise, 01 fall, 10 both, 11 none. Applies to all channels.
- `threshold` input TH_W: required edge count. 0 disables flagging.
- `clr` input 1: synchronous clear of window, counts, flags, sticky and hit counter.
- `flag_out` output N_CH: one-cycle pulse per channel on each new threshold crossing; registered.
- `cond_out` output N_CH: level, count >= threshold (qualified), combinational from registered count.
- `sticky` output N_CH: set by `flag_out`, held until `clr`.
- `any_flag` output 1: OR of `flag_out`.
- `hit_count` output 16: saturating total of `flag_out` pulses across all channels.

## Operation
- Per channel, `sig_q` holds `sig_in` from the previous cycle.
- Edge event: rise = `sig_in & ~sig_q`; fall = `~sig_in & sig_q`; both = XOR; none = 0. The event is ANDed with `enable`.
- Window: a WIN-bit shift register per channel. The event is shifted in every cycle; the oldest bit drops out.
- `cnt` (CNT_W bits) is maintained incrementally as `cnt + new - oldest`. Invariant: `cnt == popcount(window)`. It never exceeds WIN and never underflows.
- Condition: `cond = (threshold != 0) && ({0,cnt} >= {0,threshold})`. The comparison is zero-extended to the wider of CNT_W and TH_W. If `threshold > WIN`, the condition is never true.
- Flag: register `cond_q <= cond` and `flag_out <= cond & ~cond_q`. This gives exactly one pulse per rising of `cond`. Re-arm requires `cond` to be low for at least one cycle.
- `sticky[i] <= sticky[i] | flag_out[i]`.
- `hit_count` adds popcount(`flag_out`) each cycle and saturates at 0xFFFF. It never wraps.
- `enable` low: the window keeps shifting with zero events and so drains. `cond` and flags follow the draining count.
- `edge_mode`/`threshold` changes take effect on the next edge. The window content is not cleared.
- `clr` has highest priority. On the next clock, window, `cnt`, `cond_q`, `flag_out`, `sticky` and `hit_count` all become 0. `sig_q` keeps tracking `sig_in`, so `clr` creates no spurious edge.
- `clr` together with a qualifying event: `clr` wins and the event is discarded.
- `clr` together with an active `flag_out`: the pulse still appears this cycle, but it is not added to `sticky`/`hit_count`.

## Timing
- Reset values (async, immediate): `sig_q`, window, `cnt`, `cond_q`, `flag_out`, `sticky`, `hit_count` are all 0. Consequently `cond_out`, `any_flag` = 0.
- Because `sig_q` resets to 0, an input already high at the first clock after reset counts as a rising edge (rise/both modes).
- Latency, edge to `cnt`: an edge present before clock k is counted after clock k.
- Latency, `cnt` to `cond_out`: same cycle as `cnt` (combinational).
- Latency, `cnt` to `flag_out`: `flag_out` is high for the cycle after clock k+1, one cycle after `cond_out` rises.
- Window span: an event shifted in at clock k contributes to `cnt` through clock k+WIN-1 and leaves at clock k+WIN.
- Reset asserted mid-burst: all state is lost immediately. No flag is generated for edges before reset deassertion.

## Test plan
- **Basic burst.** WIN=5, threshold=3, rise, ch0 pulses high 1 cycle every 2 cycles (3 rises within 5 cycles) -> `cond_out[0]` rises one cycle after the 3rd counted edge; single `flag_out[0]` pulse one cycle later; `sticky[0]`=1; `hit_count`=1.
- **Sparse edges / spacing.**
  - ch0 rises every 3 cycles, WIN=5, th=3 -> `cnt` never exceeds 2; no flag.
  - Continued burst keeping `cond` high -> exactly one pulse until `cnt` drops below 3, then a new burst gives a second pulse.
- **Edge modes.** With ch1 toggling every cycle and th=4:
  - both -> flag after 4 transitions;
  - fall -> counts only falls;
  - none -> `cnt` stays 0.
- **Thresholds.**
  - threshold=0 -> no flag despite full window.
  - threshold=WIN+1 -> never fires.
  - threshold=WIN with an edge every cycle (mode both, toggling) -> fires.
- **Clear and enable.**
  - `clr` asserted while `cnt[0]`=3 -> next cycle all counts/sticky/`hit_count`=0, no flag.
  - `enable` dropped mid-burst -> `cnt` drains to 0 within WIN cycles.
  - Async `rst_n` pulse mid-window -> all outputs 0 immediately.
- **Multi-channel and saturation.**
  - All 4 channels burst simultaneously -> `flag_out`=4'hF, `any_flag`=1, `hit_count` +4 in one cycle.
  - Preload near 0xFFFF by repeated bursts -> holds at 0xFFFF.

Source files
------------

// File: rtl/edge_burst_det.sv
// edge_burst_det: per-channel sliding-window edge counter with threshold flag,
// sticky status and a saturating hit counter shared by all channels.
module edge_burst_det #(
    parameter int N_CH = 4,
    parameter int WIN  = 8,
    parameter int TH_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   sig_in,
    input  logic              enable,
    input  logic [1:0]        edge_mode,
    input  logic [TH_W-1:0]   threshold,
    input  logic              clr,
    output logic [N_CH-1:0]   flag_out,
    output logic [N_CH-1:0]   cond_out,
    output logic [N_CH-1:0]   sticky,
    output logic              any_flag,
    output logic [15:0]       hit_count
);

    localparam int CNT_W = $clog2(WIN + 1);
    // Count and threshold are compared zero-extended to the wider of the two,
    // so a threshold above WIN simply never matches.
    localparam int CMP_W = (CNT_W > TH_W) ? CNT_W : TH_W;
    localparam int PC_W  = $clog2(N_CH + 1);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [N_CH-1:0]  flag_vec;
    logic [N_CH-1:0]  cond_vec;
    logic [N_CH-1:0]  sticky_vec;
    logic             thr_nz;
    logic [CMP_W-1:0] thr_ext;

    assign thr_nz  = (threshold != '0);
    assign thr_ext = CMP_W'(threshold);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             sig_q;
            logic [WIN-1:0]   win_q, win_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             cond_q, cond_d;
            logic             flag_q, flag_d;
            logic             sticky_q, sticky_d;
            logic             evt_c;
            logic             cond_c;

            // Qualified edge event for this channel, gated by enable.
            always_comb begin
                evt_c = 1'b0;
                case (edge_mode)
                    MODE_RISE: evt_c =  sig_in[gi] & ~sig_q;
                    MODE_FALL: evt_c = ~sig_in[gi] &  sig_q;
                    MODE_BOTH: evt_c =  sig_in[gi] ^  sig_q;
                    default:   evt_c = 1'b0;
                endcase
                evt_c = evt_c & enable;
            end

            assign cond_c = thr_nz && (CMP_W'(cnt_q) >= thr_ext);

            // Window shift, incremental count, flag edge detect and sticky; clr wins.
            always_comb begin
                win_d    = {win_q[WIN-2:0], evt_c};
                cnt_d    = cnt_q + CNT_W'(evt_c) - CNT_W'(win_q[WIN-1]);
                cond_d   = cond_c;
                flag_d   = cond_c & ~cond_q;
                sticky_d = sticky_q | flag_q;
                if (clr) begin
                    win_d    = '0;
                    cnt_d    = '0;
                    cond_d   = 1'b0;
                    flag_d   = 1'b0;
                    sticky_d = 1'b0;
                end
            end

            // Channel state registers; sig_q tracks the input even during clr.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sig_q    <= 1'b0;
                    win_q    <= '0;
                    cnt_q    <= '0;
                    cond_q   <= 1'b0;
                    flag_q   <= 1'b0;
                    sticky_q <= 1'b0;
                end else begin
                    sig_q    <= sig_in[gi];
                    win_q    <= win_d;
                    cnt_q    <= cnt_d;
                    cond_q   <= cond_d;
                    flag_q   <= flag_d;
                    sticky_q <= sticky_d;
                end
            end

            assign flag_vec[gi]   = flag_q;
            assign cond_vec[gi]   = cond_c;
            assign sticky_vec[gi] = sticky_q;
        end
    endgenerate

    logic [PC_W-1:0] flag_pop;
    logic [16:0]     hit_sum;
    logic [15:0]     hit_q, hit_d;

    // Add this cycle's flag pulses to the hit counter, saturating at 0xFFFF.
    always_comb begin
        flag_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            flag_pop = flag_pop + PC_W'(flag_vec[i]);
        end
        hit_sum = {1'b0, hit_q} + 17'(flag_pop);
        hit_d   = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
        if (clr) begin
            hit_d = '0;
        end
    end

    // Hit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign flag_out  = flag_vec;
    assign cond_out  = cond_vec;
    assign sticky    = sticky_vec;
    assign any_flag  = |flag_vec;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_edge_burst_det.sv
// Directed testbench for edge_burst_det (4 channels, 5-cycle window).
module tb_edge_burst_det;

    localparam int N_CH = 4;
    localparam int WIN  = 5;
    localparam int TH_W = 4;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] sig_in;
    logic            enable;
    logic [1:0]      edge_mode;
    logic [TH_W-1:0] threshold;
    logic            clr;
    logic [N_CH-1:0] flag_out;
    logic [N_CH-1:0] cond_out;
    logic [N_CH-1:0] sticky;
    logic            any_flag;
    logic [15:0]     hit_count;

    int checks   = 0;
    int failures = 0;

    edge_burst_det #(
        .N_CH(N_CH),
        .WIN (WIN),
        .TH_W(TH_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .enable   (enable),
        .edge_mode(edge_mode),
        .threshold(threshold),
        .clr      (clr),
        .flag_out (flag_out),
        .cond_out (cond_out),
        .sticky   (sticky),
        .any_flag (any_flag),
        .hit_count(hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr;
        clr    = 1'b1;
        sig_in = '0;
        step;
        clr    = 1'b0;
    endtask

    int nflag;
    int seen;

    initial begin
        rst_n = 1'b1; sig_in = '0; enable = 1'b1; edge_mode = 2'b00;
        threshold = 4'd3; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_flag",   32'(flag_out),  32'h0);
        check("rst_cond",   32'(cond_out),  32'h0);
        check("rst_sticky", 32'(sticky),    32'h0);
        check("rst_any",    32'(any_flag),  32'h0);
        check("rst_hit",    32'(hit_count), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic burst: rise, th=3, ch0 high every other cycle
        for (int i = 0; i < 4; i++) begin
            sig_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step;
        end
        check("burst_cond_c4", 32'(cond_out), 32'h0);
        sig_in = 4'b0001; step;
        check("burst_cond_c5", 32'(cond_out), 32'h1);
        check("burst_flag_c5", 32'(flag_out), 32'h0);
        sig_in = 4'b0000; step;
        check("burst_flag_c6", 32'(flag_out), 32'h1);
        check("burst_any_c6",  32'(any_flag), 32'h1);
        check("burst_cond_c6", 32'(cond_out), 32'h0);
        step;
        check("burst_flag_c7", 32'(flag_out),  32'h0);
        check("burst_sticky",  32'(sticky),    32'h1);
        check("burst_hit",     32'(hit_count), 32'h1);

        // Sparse edges: rise every 3 cycles never reaches 3
        do_clr;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            sig_in = (i % 3 == 0) ? 4'b0001 : 4'b0000;
            step;
            seen += int'(cond_out[0]) + int'(flag_out[0]);
        end
        check("sparse_no_cond_flag", 32'(seen), 32'h0);

        // Sustained condition gives one pulse; re-arm after drain gives another
        edge_mode = 2'b10; threshold = 4'd3; nflag = 0;
        for (int i = 0; i < 10; i++) begin
            sig_in[0] = ~sig_in[0]; step; nflag += int'(flag_out[0]);
        end
        check("sustain_cond", 32'(cond_out), 32'h1);
        check("sustain_one_pulse", 32'(nflag), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step; nflag += int'(flag_out[0]);
        end
        check("drain_cond", 32'(cond_out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            sig_in[0] = ~sig_in[0]; step; nflag += int'(flag_out[0]);
        end
        for (int i = 0; i < 6; i++) begin
            step; nflag += int'(flag_out[0]);
        end
        check("rearm_pulses", 32'(nflag),     32'd2);
        check("rearm_hit",    32'(hit_count), 32'd2);

        // Edge mode both on ch1, th=4
        do_clr;
        edge_mode = 2'b10; threshold = 4'd4;
        for (int i = 0; i < 3; i++) begin
            sig_in[1] = ~sig_in[1]; step;
        end
        check("both_cond_c3", 32'(cond_out), 32'h0);
        sig_in[1] = ~sig_in[1]; step;
        check("both_cond_c4", 32'(cond_out), 32'h2);
        sig_in[1] = ~sig_in[1]; step;
        check("both_flag_c5", 32'(flag_out), 32'h2);

        // Fall mode: only falls counted
        do_clr;
        edge_mode = 2'b01; threshold = 4'd4; seen = 0;
        for (int i = 0; i < 9; i++) begin
            sig_in[1] = ~sig_in[1]; step; seen += int'(cond_out[1]);
        end
        check("fall_no_cond_th4", 32'(seen), 32'h0);
        threshold = 4'd2; #1;
        check("fall_cond_th2", 32'(cond_out), 32'h2);
        threshold = 4'd3; #1;
        check("fall_cond_th3", 32'(cond_out), 32'h0);

        // None mode: nothing counted
        do_clr;
        edge_mode = 2'b11; threshold = 4'd4;
        for (int i = 0; i < 8; i++) begin
            sig_in[1] = ~sig_in[1]; step;
        end
        threshold = 4'd1; #1;
        check("none_cond_th1", 32'(cond_out), 32'h0);

        // Thresholds: 0 and WIN+1 never fire, WIN fires
        do_clr;
        edge_mode = 2'b10; threshold = 4'd0; nflag = 0;
        for (int i = 0; i < 8; i++) begin
            sig_in[0] = ~sig_in[0]; step; nflag += int'(flag_out[0]);
        end
        check("th0_cond", 32'(cond_out), 32'h0);
        threshold = 4'd6;
        for (int i = 0; i < 4; i++) begin
            sig_in[0] = ~sig_in[0]; step; nflag += int'(flag_out[0]);
        end
        check("th6_cond", 32'(cond_out), 32'h0);
        check("th0_th6_no_flag", 32'(nflag), 32'h0);
        threshold = 4'd5;
        sig_in[0] = ~sig_in[0]; step;
        check("th5_cond", 32'(cond_out), 32'h1);
        check("th5_flag", 32'(flag_out), 32'h1);

        // Clear while cnt=3 suppresses a pending flag and zeroes status
        do_clr;
        edge_mode = 2'b00; threshold = 4'd3;
        for (int i = 0; i < 7; i++) begin
            sig_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step;
        end
        check("preclr_cond",   32'(cond_out),  32'h1);
        check("preclr_sticky", 32'(sticky),    32'h1);
        check("preclr_hit",    32'(hit_count), 32'h1);
        clr = 1'b1; sig_in = 4'b0000; step; clr = 1'b0;
        check("clr_cond",   32'(cond_out),  32'h0);
        check("clr_flag",   32'(flag_out),  32'h0);
        check("clr_sticky", 32'(sticky),    32'h0);
        check("clr_hit",    32'(hit_count), 32'h0);

        // Clear coinciding with a visible flag: pulse not accumulated
        for (int i = 0; i < 6; i++) begin
            sig_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step;
        end
        check("clrflag_flag", 32'(flag_out), 32'h1);
        clr = 1'b1; step; clr = 1'b0;
        check("clrflag_sticky", 32'(sticky),    32'h0);
        check("clrflag_hit",    32'(hit_count), 32'h0);

        // Clear with a qualifying edge discards it; no spurious edge afterwards
        threshold = 4'd1; clr = 1'b1; sig_in = 4'b0001; step; clr = 1'b0;
        check("clr_evt_cond", 32'(cond_out), 32'h0);
        step;
        check("clr_no_spurious", 32'(cond_out), 32'h0);

        // Enable dropped: window drains within WIN cycles
        edge_mode = 2'b10; threshold = 4'd1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sig_in[0] = ~sig_in[0]; step;
        end
        check("en_sticky", 32'(sticky),    32'h1);
        check("en_hit",    32'(hit_count), 32'h1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig_in[0] = ~sig_in[0]; step;
        end
        check("en_drain_c7", 32'(cond_out), 32'h1);
        sig_in[0] = ~sig_in[0]; step;
        check("en_drain_c8", 32'(cond_out), 32'h0);

        // Async reset mid-window
        enable = 1'b1;
        sig_in[0] = ~sig_in[0]; step;
        check("prerst_cond", 32'(cond_out), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cond",   32'(cond_out),  32'h0);
        check("arst_sticky", 32'(sticky),    32'h0);
        check("arst_hit",    32'(hit_count), 32'h0);
        check("arst_any",    32'(any_flag),  32'h0);
        sig_in = 4'b0001; edge_mode = 2'b00; threshold = 4'd1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step;
        check("post_rst_rise", 32'(cond_out), 32'h1);

        // All channels burst together
        edge_mode = 2'b10; threshold = 4'd3;
        do_clr;
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in; step;
        end
        check("multi_cond", 32'(cond_out), 32'hF);
        sig_in = ~sig_in; step;
        check("multi_flag", 32'(flag_out),  32'hF);
        check("multi_any",  32'(any_flag),  32'h1);
        check("multi_hit0", 32'(hit_count), 32'h0);
        sig_in = ~sig_in; step;
        check("multi_hit4", 32'(hit_count), 32'd4);

        // Saturation: repeated bursts on all channels, 2 pulses per cycle on average
        edge_mode = 2'b00; threshold = 4'd3;
        do_clr;
        for (int i = 0; i < 1000; i++) begin
            sig_in = (i % 2 == 0) ? 4'hF : 4'h0;
            step;
        end
        check("sat_mid_hit", 32'(hit_count), 32'd1988);
        for (int i = 1000; i < 40000; i++) begin
            sig_in = (i % 2 == 0) ? 4'hF : 4'h0;
            step;
        end
        check("sat_hit", 32'(hit_count), 32'hFFFF);
        for (int i = 40000; i < 40010; i++) begin
            sig_in = (i % 2 == 0) ? 4'hF : 4'h0;
            step;
        end
        check("sat_hold", 32'(hit_count), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
